// File: rtl/weight_fifo_loader.sv
// rtl/weight_fifo_loader.sv - weight SRAM to weight FIFO row loader (optional macro: WEIGHT_LOADER_ZERO_PAD_EN)
module weight_fifo_loader #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_INPUTS = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [ADDR_WIDTH-1:0]             base_addr,
   input  logic [FIFO_INPUTS-1:0]            col_mask,
   input  logic                              stall,
   output logic                              mem_rd_en,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   input  logic [DATA_WIDTH*FIFO_INPUTS-1:0] mem_rd_data,
   output logic [FIFO_INPUTS-1:0]            fifo_en,
   output logic [DATA_WIDTH*FIFO_INPUTS-1:0] fifo_weight,
   output logic                              busy,
   output logic                              done
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t                            state;
   logic [ADDR_WIDTH-1:0]             base_r;
   logic [ADDR_WIDTH-1:0]             addr_hold;
   logic [FIFO_INPUTS-1:0]            mask_r;
   logic [CW-1:0]                     issue_cnt;
   logic [CW-1:0]                     push_cnt;
   logic                              rd_v1;
   logic                              issue;
   logic [ADDR_WIDTH-1:0]             issue_addr;
   logic [FIFO_INPUTS-1:0]            push_en;
   logic [DATA_WIDTH*FIFO_INPUTS-1:0] push_data;

   // Stall must suppress the read in the same cycle, so the strobe is decoded from state
   assign issue      = (state == LOAD) && !stall;
   assign issue_addr = base_r + ADDR_WIDTH'(issue_cnt);
   assign mem_rd_en  = issue;
   assign mem_addr   = issue ? issue_addr : addr_hold;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // Column enables and data presented to the FIFO for the row arriving from memory
   always_comb begin
      push_en   = '0;
      push_data = '0;
`ifdef WEIGHT_LOADER_ZERO_PAD_EN
      push_en = '1;
      for (int c = 0; c < FIFO_INPUTS; c++) begin
         push_data[c*DATA_WIDTH +: DATA_WIDTH] =
            mask_r[c] ? mem_rd_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
`else
      push_en   = mask_r;
      push_data = mem_rd_data;
`endif
   end

   // Control FSM: capture request, issue FIFO_DEPTH reads, wait for the last push, pulse done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         base_r    <= '0;
         mask_r    <= '0;
         addr_hold <= '0;
         issue_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_r    <= base_addr;
                  mask_r    <= col_mask;
                  issue_cnt <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (!stall) begin
                  addr_hold <= issue_addr;
                  issue_cnt <= issue_cnt + 1'b1;
                  if (issue_cnt == CW'(FIFO_DEPTH - 1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (push_cnt == CW'(FIFO_DEPTH)) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Push pipeline: a read issued in cycle t is pushed in t+2, independent of stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_v1       <= 1'b0;
         fifo_en     <= '0;
         fifo_weight <= '0;
         push_cnt    <= '0;
      end else begin
         rd_v1   <= issue;
         fifo_en <= rd_v1 ? push_en : '0;
         if (rd_v1) begin
            fifo_weight <= push_data;
            push_cnt    <= push_cnt + 1'b1;
         end else if (state == DONE) begin
            push_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_weight_fifo_loader.sv
// tb/tb_weight_fifo_loader.sv - self-checking bench for weight_fifo_loader
module tb_weight_fifo_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [3:0]  col_mask;
   logic        stall;
   logic        mem_rd_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rd_data;
   logic [3:0]  fifo_en;
   logic [31:0] fifo_weight;
   logic        busy;
   logic        done;

   logic [31:0] mem [256];
   int          n_checks = 0;
   int          n_fail = 0;

   weight_fifo_loader #(
      .DATA_WIDTH(8), .FIFO_INPUTS(4), .FIFO_DEPTH(4), .ADDR_WIDTH(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .col_mask(col_mask), .stall(stall), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .fifo_en(fifo_en),
      .fifo_weight(fifo_weight), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Weight SRAM model: one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_en(input logic [3:0] mask);
`ifdef WEIGHT_LOADER_ZERO_PAD_EN
      return 4'hF;
`else
      return mask;
`endif
   endfunction

   function automatic logic [31:0] exp_row(input logic [31:0] row, input logic [3:0] mask);
      logic [31:0] r;
      r = row;
`ifdef WEIGHT_LOADER_ZERO_PAD_EN
      for (int i = 0; i < 4; i++) if (!mask[i]) r[i*8 +: 8] = 8'h00;
`endif
      return r;
   endfunction

   // One load; cycle 0 is the start cycle. Expected issue cycles come from the stall
   // pattern alone: the n-th unstalled cycle after start issues row n.
   task automatic run_load(input logic [7:0] base, input logic [3:0] mask,
                           input logic [31:0] stall_bits, input int second_start);
      int issue_cyc [DEPTH];
      int k;
      int last;
      int iss;
      int psh;
      int prev;
      logic [7:0] a;
      k = 0;
      for (int c = 1; c < 32; c++) begin
         if (k < DEPTH && !stall_bits[c]) begin
            issue_cyc[k] = c;
            k++;
         end
      end
      last = issue_cyc[DEPTH-1] + 3;
      for (int c = 0; c <= last + 1; c++) begin
         @(negedge clk);
         stall     = (c < 32) ? stall_bits[c] : 1'b0;
         start     = (c == 0) || (c == second_start);
         base_addr = (c == 0) ? base : 8'h40;
         col_mask  = (c == 0) ? mask : ~mask;
         #1;
         if (c >= 1) begin
            iss  = -1;
            psh  = -1;
            prev = 0;
            for (int i = 0; i < DEPTH; i++) begin
               if (issue_cyc[i] == c) iss = i;
               if (issue_cyc[i] + 2 == c) psh = i;
               if (issue_cyc[i] < c) prev++;
            end
            check("rd_en", 32'(mem_rd_en), 32'(iss >= 0));
            if (iss >= 0) begin
               a = base + 8'(iss);
               check("addr", 32'(mem_addr), 32'(a));
            end else if (prev > 0 && prev < DEPTH) begin
               a = base + 8'(prev - 1);
               check("addr_hold", 32'(mem_addr), 32'(a));
            end
            check("fifo_en", 32'(fifo_en), (psh >= 0) ? 32'(exp_en(mask)) : 32'd0);
            if (psh >= 0) begin
               a = base + 8'(psh);
               check("weight", fifo_weight, exp_row(mem[a], mask));
            end
            check("done", 32'(done), 32'(c == last));
            check("busy", 32'(busy), 32'(c <= last));
         end
      end
      start = 1'b0;
      stall = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_en"}, 32'(fifo_en), 32'd0);
      check({tag, "_weight"}, fifo_weight, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      reset = 1'b1; start = 1'b0; stall = 1'b0; base_addr = '0; col_mask = '0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // Basic, stall in cycles 2-3, wrap with partial mask, start while busy
      run_load(8'h10, 4'hF, 32'h0, -1);
      run_load(8'h10, 4'hF, 32'h0000_000C, -1);
      run_load(8'hFE, 4'b1010, 32'h0, -1);
      run_load(8'h10, 4'hF, 32'h0, 2);

      // Reset in cycle 4 of a load
      @(negedge clk);
      start = 1'b1; base_addr = 8'h10; col_mask = 4'hF;
      repeat (3) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         #1;
         check("post_rst_en", 32'(fifo_en), 32'd0);
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
      end
      run_load(8'h10, 4'hF, 32'h0, -1);

      // Empty mask
      run_load(8'h10, 4'h0, 32'h0, -1);

      // Randomized loads with random stalls
      repeat (10) begin
         run_load(8'($urandom), 4'($urandom), $urandom & 32'h00FF_FFFE, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
